// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite response codes, channel FSM states and the register data width.
// Also holds the address-window decode helper used by both read and write paths.
package axi4lite_pkg;

   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wstate_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rstate_t;

   // Offset form avoids overflow when base + span wraps past 2^32.
   function automatic logic addr_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] span);
      return (addr >= base) && ((addr - base) < span);
   endfunction

endpackage

// File: rtl/axi4lite_regfile.sv
// NREGS x 32 register storage: one byte-strobed write port, one asynchronous read port.
// Write takes effect on the edge where we=1; reads see the pre-write value during that cycle.
module axi4lite_regfile
   import axi4lite_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int IW    = 4
)(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              we,
   input  logic [IW-1:0]     widx,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   input  logic [IW-1:0]     ridx,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [NREGS];

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = (int'(ridx) < NREGS) ? mem[ridx] : '0;

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave over a bank of NREGS 32-bit registers; B and R arrive 1 cycle after capture.
// All READYs are registered; B/R outputs hold until BREADY/RREADY, blocking new requests meanwhile.
module axi4lite_reg_slave
   import axi4lite_pkg::*;
#(
   parameter int          N     = 4,
   parameter int          NREGS = 16,
   parameter logic [31:0] BASE  = 32'h100
)(
   input  logic           Clk,
   input  logic           Rst,
   input  logic [31:0]    AWADDR,
   input  logic [2:0]     AWPROT,
   input  logic           AWVALID,
   output logic           AWREADY,
   input  logic [8*N-1:0] WDATA,
   input  logic [N-1:0]   WSTRB,
   input  logic           WVALID,
   output logic           WREADY,
   output logic [1:0]     BRESP,
   output logic           BVALID,
   input  logic           BREADY,
   input  logic [31:0]    ARADDR,
   input  logic [2:0]     ARPROT,
   input  logic           ARVALID,
   output logic           ARREADY,
   output logic [8*N-1:0] RDATA,
   output logic [1:0]     RRESP,
   output logic           RVALID,
   input  logic           RREADY
);

   localparam int          IW   = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [31:0] SPAN = 32'(4 * NREGS);

   wstate_t        wstate;
   rstate_t        rstate;
   logic           aw_got, w_got;
   logic [31:0]    awaddr_q;
   logic [8*N-1:0] wdata_q;
   logic [N-1:0]   wstrb_q;

   logic           aw_hs, w_hs, ar_hs, commit, whit, rhit;
   logic [IW-1:0]  widx, ridx;
   logic [31:0]    rd_word;
   logic           unused_prot;

   assign unused_prot = ^{AWPROT, ARPROT};

   assign aw_hs  = AWVALID & AWREADY;
   assign w_hs   = WVALID & WREADY;
   assign ar_hs  = ARVALID & ARREADY;
   assign commit = (wstate == W_IDLE) & aw_got & w_got;

   assign whit = addr_hit(awaddr_q, BASE, SPAN);
   assign rhit = addr_hit(ARADDR, BASE, SPAN);
   assign widx = IW'((awaddr_q - BASE) >> 2);
   assign ridx = IW'((ARADDR - BASE) >> 2);

   axi4lite_regfile #(
      .NREGS (NREGS),
      .IW    (IW)
   ) u_regfile (
      .Clk   (Clk),
      .Rst   (Rst),
      .we    (commit & whit),
      .widx  (widx),
      .wdata (wdata_q),
      .wstrb (wstrb_q),
      .ridx  (ridx),
      .rdata (rd_word)
   );

   // AW and W are captured independently; the commit happens on the edge after both are held.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wstate   <= W_IDLE;
         aw_got   <= 1'b0;
         w_got    <= 1'b0;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         AWREADY  <= 1'b0;
         WREADY   <= 1'b0;
         BVALID   <= 1'b0;
         BRESP    <= OKAY;
      end else begin
         case (wstate)
            W_IDLE: begin
               if (commit) begin
                  wstate <= W_RESP;
                  aw_got <= 1'b0;
                  w_got  <= 1'b0;
                  BVALID <= 1'b1;
                  BRESP  <= whit ? OKAY : SLVERR;
               end else begin
                  if (aw_hs) begin
                     aw_got   <= 1'b1;
                     awaddr_q <= AWADDR;
                     AWREADY  <= 1'b0;
                  end else if (!aw_got) begin
                     AWREADY  <= 1'b1;
                  end
                  if (w_hs) begin
                     w_got   <= 1'b1;
                     wdata_q <= WDATA;
                     wstrb_q <= WSTRB;
                     WREADY  <= 1'b0;
                  end else if (!w_got) begin
                     WREADY  <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (BREADY) begin
                  wstate  <= W_IDLE;
                  BVALID  <= 1'b0;
                  AWREADY <= 1'b1;
                  WREADY  <= 1'b1;
               end
            end
         endcase
      end
   end

   // Read data is sampled from the async port on the AR edge, so a same-edge commit is not seen.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         rstate  <= R_IDLE;
         ARREADY <= 1'b0;
         RVALID  <= 1'b0;
         RDATA   <= '0;
         RRESP   <= OKAY;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (ar_hs) begin
                  rstate  <= R_DATA;
                  ARREADY <= 1'b0;
                  RVALID  <= 1'b1;
                  RDATA   <= rhit ? rd_word : '0;
                  RRESP   <= rhit ? OKAY : SLVERR;
               end else begin
                  ARREADY <= 1'b1;
               end
            end
            R_DATA: begin
               if (RREADY) begin
                  rstate  <= R_IDLE;
                  RVALID  <= 1'b0;
                  ARREADY <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Bench for axi4lite_reg_slave: directed vector table, hand-built timing sequences,
// then random traffic against an array-based register model.
module tb_axi4lite_reg_slave;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic [31:0] AWADDR = '0;
   logic [2:0]  AWPROT = '0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] WDATA = '0;
   logic [3:0]  WSTRB = '0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY = 1'b0;
   logic [31:0] ARADDR = '0;
   logic [2:0]  ARPROT = '0;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [31:0] mdl [16];

   axi4lite_reg_slave #(.N(4), .NREGS(16), .BASE(32'h100)) dut (
      .Clk(Clk), .Rst(Rst),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: handshake did not complete within cycle budget", name);
   endtask

   // Reference model: registers as a plain array, addresses by arithmetic window test.
   function automatic bit mdl_hit(input logic [31:0] a);
      return (a >= 32'h100) && (a < 32'h140);
   endfunction

   task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int idx;
      if (mdl_hit(a)) begin
         idx = int'((a - 32'h100) / 4);
         for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
         resp = 2'b00;
      end else begin
         resp = 2'b10;
      end
   endtask

   task automatic mdl_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      if (mdl_hit(a)) begin
         d    = mdl[int'((a - 32'h100) / 4)];
         resp = 2'b00;
      end else begin
         d    = 32'h0;
         resp = 2'b10;
      end
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
   endtask

   // All drivers are called at posedge+1 and return at posedge+1.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
      bit ad, wd, ahs, whs;
      int n;
      AWADDR = a; WDATA = d; WSTRB = s;
      AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
      ad = 0; wd = 0; n = 0;
      while (!(ad && wd) && n < 50) begin
         ahs = AWVALID && AWREADY;
         whs = WVALID && WREADY;
         @(posedge Clk); #1;
         if (ahs) begin ad = 1; AWVALID = 1'b0; end
         if (whs) begin wd = 1; WVALID = 1'b0; end
         n++;
      end
      AWVALID = 1'b0; WVALID = 1'b0;
      n = 0;
      while (!BVALID && n < 50) begin @(posedge Clk); #1; n++; end
      if (!BVALID) begin
         timeout_fail("write_bvalid");
         resp = 2'bxx;
      end else begin
         resp = BRESP;
      end
      @(posedge Clk); #1;
      BREADY = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      bit ahs, done;
      int n;
      ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
      done = 0; n = 0;
      while (!done && n < 50) begin
         ahs = ARVALID && ARREADY;
         @(posedge Clk); #1;
         if (ahs) begin done = 1; ARVALID = 1'b0; end
         n++;
      end
      ARVALID = 1'b0;
      n = 0;
      while (!RVALID && n < 50) begin @(posedge Clk); #1; n++; end
      if (!RVALID) begin
         timeout_fail("read_rvalid");
         d = 'x; resp = 2'bxx;
      end else begin
         d = RDATA; resp = RRESP;
      end
      @(posedge Clk); #1;
      RREADY = 1'b0;
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vt[$];

   initial begin
      logic [1:0]  r, er;
      logic [31:0] d, ed, old;

      vt.push_back('{1'b1, 32'h100,      32'h12345678, 4'b1011, 32'h0,        2'b00});
      vt.push_back('{1'b0, 32'h100,      32'h0,        4'b0000, 32'h12005678, 2'b00});
      vt.push_back('{1'b1, 32'h12345678, 32'h0000ABCD, 4'b1111, 32'h0,        2'b10});
      vt.push_back('{1'b0, 32'h12345678, 32'h0,        4'b0000, 32'h0,        2'b10});
      vt.push_back('{1'b0, 32'h100,      32'h0,        4'b0000, 32'h12005678, 2'b00});
      vt.push_back('{1'b1, 32'h103,      32'hAABBCCDD, 4'b0000, 32'h0,        2'b00});
      vt.push_back('{1'b0, 32'h101,      32'h0,        4'b0000, 32'h12005678, 2'b00});
      vt.push_back('{1'b1, 32'h13F,      32'hCAFEF00D, 4'b1111, 32'h0,        2'b00});
      vt.push_back('{1'b0, 32'h13C,      32'h0,        4'b0000, 32'hCAFEF00D, 2'b00});
      vt.push_back('{1'b1, 32'h140,      32'h11111111, 4'b1111, 32'h0,        2'b10});
      vt.push_back('{1'b0, 32'h140,      32'h0,        4'b0000, 32'h0,        2'b10});
      vt.push_back('{1'b0, 32'h0FC,      32'h0,        4'b0000, 32'h0,        2'b10});
      vt.push_back('{1'b1, 32'h106,      32'h11223344, 4'b0100, 32'h0,        2'b00});
      vt.push_back('{1'b0, 32'h104,      32'h0,        4'b0000, 32'h00220000, 2'b00});

      // Reset state
      mdl_reset();
      repeat (2) @(posedge Clk);
      #1;
      check("rst_readys", {AWREADY, WREADY, ARREADY}, 3'b000);
      check("rst_valids", {BVALID, RVALID}, 2'b00);
      check("rst_resps", {BRESP, RRESP}, 4'h0);
      check("rst_rdata", RDATA, 32'h0);
      Rst = 1'b1;
      @(posedge Clk); #1;
      check("readys_after_rst", {AWREADY, WREADY, ARREADY}, 3'b111);

      // Directed vector table
      foreach (vt[i]) begin
         if (vt[i].wr) begin
            do_write(vt[i].addr, vt[i].data, vt[i].strb, r);
            mdl_write(vt[i].addr, vt[i].data, vt[i].strb, er);
            check($sformatf("vec%0d_bresp", i), r, vt[i].exp_resp);
         end else begin
            do_read(vt[i].addr, d, r);
            check($sformatf("vec%0d_rdata", i), d, vt[i].exp_data);
            check($sformatf("vec%0d_rresp", i), r, vt[i].exp_resp);
         end
      end

      // W arrives 3 cycles ahead of AW; B must follow AW capture by one cycle
      WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
      @(posedge Clk); #1;
      WVALID = 1'b0;
      check("w_first_wready_low", WREADY, 1'b0);
      repeat (2) begin @(posedge Clk); #1; end
      check("w_first_no_b_yet", BVALID, 1'b0);
      AWADDR = 32'h13C; AWVALID = 1'b1;
      check("w_first_awready", AWREADY, 1'b1);
      @(posedge Clk); #1;
      AWVALID = 1'b0;
      check("b_not_at_aw_edge", BVALID, 1'b0);
      @(posedge Clk); #1;
      check("b_one_after_aw", {BVALID, BRESP}, 3'b100);
      mdl_write(32'h13C, 32'hDEADBEEF, 4'hF, er);
      BREADY = 1'b1;
      @(posedge Clk); #1;
      BREADY = 1'b0;
      check("b_done_idle", {BVALID, AWREADY, WREADY}, 3'b011);
      do_read(32'h13C, d, r);
      check("w_first_readback", d, 32'hDEADBEEF);

      // B stalled by BREADY=0, then R stalled by RREADY=0
      AWADDR = 32'h108; WDATA = 32'h87654321; WSTRB = 4'hF;
      AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
      @(posedge Clk); #1;
      AWVALID = 1'b0; WVALID = 1'b0;
      @(posedge Clk); #1;
      mdl_write(32'h108, 32'h87654321, 4'hF, er);
      for (int c = 0; c < 5; c++) begin
         check($sformatf("b_stall_c%0d", c), {BVALID, BRESP, AWREADY, WREADY}, 5'b10000);
         @(posedge Clk); #1;
      end
      BREADY = 1'b1;
      @(posedge Clk); #1;
      BREADY = 1'b0;
      ARADDR = 32'h108; ARVALID = 1'b1; RREADY = 1'b0;
      @(posedge Clk); #1;
      ARVALID = 1'b0;
      mdl_read(32'h108, ed, er);
      for (int c = 0; c < 4; c++) begin
         @(posedge Clk); #1;
         check($sformatf("r_stall_ctl_c%0d", c), {RVALID, ARREADY, RRESP}, 4'b1000);
         check($sformatf("r_stall_data_c%0d", c), RDATA, ed);
      end
      RREADY = 1'b1;
      @(posedge Clk); #1;
      RREADY = 1'b0;
      check("r_release", {RVALID, ARREADY}, 2'b01);

      // Read handshake on the same edge as a commit to that register returns the old value
      do_write(32'h114, 32'h0BADF00D, 4'hF, r);
      mdl_write(32'h114, 32'h0BADF00D, 4'hF, er);
      mdl_read(32'h114, old, er);
      AWADDR = 32'h114; WDATA = 32'h5A5A1234; WSTRB = 4'hF;
      AWVALID = 1'b1; WVALID = 1'b1;
      @(posedge Clk); #1;
      AWVALID = 1'b0; WVALID = 1'b0;
      ARADDR = 32'h114; ARVALID = 1'b1;
      @(posedge Clk); #1;
      ARVALID = 1'b0;
      check("coll_valids", {RVALID, BVALID}, 2'b11);
      check("coll_old_data", RDATA, old);
      mdl_write(32'h114, 32'h5A5A1234, 4'hF, er);
      RREADY = 1'b1; BREADY = 1'b1;
      @(posedge Clk); #1;
      RREADY = 1'b0; BREADY = 1'b0;
      do_read(32'h114, d, r);
      mdl_read(32'h114, ed, er);
      check("coll_new_data", d, ed);

      // Reset while BVALID is pending
      AWADDR = 32'h104; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF;
      AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
      @(posedge Clk); #1;
      AWVALID = 1'b0; WVALID = 1'b0;
      @(posedge Clk); #1;
      check("pre_rst_bvalid", BVALID, 1'b1);
      #2 Rst = 1'b0;
      #1;
      check("mid_rst_outputs", {BVALID, AWREADY, WREADY, ARREADY}, 4'b0000);
      mdl_reset();
      @(posedge Clk); #1;
      Rst = 1'b1;
      @(posedge Clk); #1;
      check("readys_after_rst2", {AWREADY, WREADY, ARREADY}, 3'b111);
      do_read(32'h104, d, r);
      check("rst_cleared_104", {d, 2'b00, r}, {32'h0, 4'h0});
      do_read(32'h13C, d, r);
      check("rst_cleared_13c", d, 32'h0);

      // Random traffic against the model
      for (int k = 0; k < 80; k++) begin
         logic [31:0] a, wd;
         logic [3:0]  s;
         a  = 32'h0F0 + 32'($urandom_range(0, 32'h5F));
         if ($urandom_range(0, 15) == 0) a = $urandom;
         wd = $urandom;
         s  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            do_write(a, wd, s, r);
            mdl_write(a, wd, s, er);
            check($sformatf("rnd%0d_bresp a=%h", k, a), r, er);
         end else begin
            do_read(a, d, r);
            mdl_read(a, ed, er);
            check($sformatf("rnd%0d_read a=%h", k, a), {d, 2'b00, r}, {ed, 2'b00, er});
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
